// File: rtl/plru_replace_ctrl_pkg.sv
// Shared cache definitions: way geometry, PLRU bit positions and the
// tree-PLRU touch/victim helpers used by the controller and its model.
package plru_replace_ctrl_pkg;

    localparam int unsigned WAY_W  = 2;
    localparam int unsigned WAYS   = 4;
    localparam int unsigned PLRU_W = 3;

    // Bit positions inside one set's PLRU word
    localparam int unsigned B_ROOT = 0;  // 0: victim in ways 0/1, 1: ways 2/3
    localparam int unsigned B_LO   = 1;  // 0: way 0, 1: way 1
    localparam int unsigned B_HI   = 2;  // 0: way 2, 1: way 3

    typedef logic [WAY_W-1:0]  way_t;
    typedef logic [PLRU_W-1:0] plru_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RESP
    } state_t;

    // Make way w the most recently used; the bit off w's path is kept
    function automatic plru_t touch(plru_t bits, way_t w);
        plru_t r;
        r = bits;
        r[B_ROOT] = ~w[1];
        if (w[1]) r[B_HI] = ~w[0];
        else      r[B_LO] = ~w[0];
        return r;
    endfunction

    // Way pointed to by the PLRU tree
    function automatic way_t plru_victim(plru_t bits);
        if (!bits[B_ROOT]) return {1'b0, bits[B_LO]};
        else               return {1'b1, bits[B_HI]};
    endfunction

endpackage

// File: rtl/plru_replace_ctrl_decoder.sv
// 2-to-4 way decoder: one-hot form of a way index.
module decoder
    import plru_replace_ctrl_pkg::*;
(
    input  logic [WAY_W-1:0] way,
    output logic [WAYS-1:0]  onehot
);

    // Set the single bit selected by way
    always_comb begin
        onehot      = '0;
        onehot[way] = 1'b1;
    end

endmodule

// File: rtl/plru_replace_ctrl.sv
// Tree pseudo-LRU replacement controller for a 4-way cache. Records
// hits/fills as accesses and answers victim requests via valid/ready.
module plru_replace_ctrl
    import plru_replace_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_SETS = 16,
    localparam int unsigned SET_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             access_valid,
    input  logic [SET_W-1:0] access_set,
    input  logic [WAY_W-1:0] access_way,
    input  logic             victim_req_valid,
    output logic             victim_req_ready,
    input  logic [SET_W-1:0] victim_set,
    input  logic [WAYS-1:0]  way_valid,
    output logic             victim_valid,
    input  logic             victim_ready,
    output logic [WAY_W-1:0] victim_way,
    output logic [WAYS-1:0]  victim_onehot
);

    state_t           state_q, state_d;
    logic [SET_W-1:0] set_q;
    logic [WAYS-1:0]  wv_q;
    way_t             way_q;
    way_t             victim_d;
    logic             accept, commit, load_way;

    plru_t plru_q [NUM_SETS];
    plru_t plru_d [NUM_SETS];

    // Control registers: FSM state, latched request and registered victim
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            set_q   <= '0;
            wv_q    <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                set_q <= victim_set;
                wv_q  <= way_valid;
            end
            if (load_way) way_q <= victim_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d          = state_q;
        victim_req_ready = 1'b0;
        victim_valid     = 1'b0;
        accept           = 1'b0;
        commit           = 1'b0;
        load_way         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                victim_req_ready = 1'b1;
                if (victim_req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                load_way = 1'b1;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                victim_valid = 1'b1;
                if (victim_ready) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Victim choice: lowest invalid way first, otherwise the PLRU way
    always_comb begin
        logic found;
        found    = 1'b0;
        victim_d = plru_victim(plru_q[set_q]);
        if (wv_q != '1) begin
            for (int unsigned i = 0; i < WAYS; i++) begin
                if (!found && !wv_q[i]) begin
                    victim_d = way_t'(i);
                    found    = 1'b1;
                end
            end
        end
    end

    // Merged PLRU update: access applied first so a same-set commit leaves the victim MRU
    always_comb begin
        for (int unsigned s = 0; s < NUM_SETS; s++) begin
            plru_d[s] = plru_q[s];
            if (access_valid && access_set == SET_W'(s))
                plru_d[s] = touch(plru_d[s], access_way);
            if (commit && set_q == SET_W'(s))
                plru_d[s] = touch(plru_d[s], way_q);
        end
    end

    // PLRU bit array storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
        end else begin
            for (int unsigned s = 0; s < NUM_SETS; s++) plru_q[s] <= plru_d[s];
        end
    end

    assign victim_way = way_q;

    decoder u_decoder (
        .way    (way_q),
        .onehot (victim_onehot)
    );

endmodule

// File: doc/plru_replace_ctrl.md
# plru_replace_ctrl

Tree pseudo-LRU replacement controller for the 4-way set-associative cache. It keeps 3 PLRU bits per set and records every hit or fill as an access. On a miss it answers a victim request with the way to replace, preferring invalid ways, through a valid/ready handshake. The cache controller uses the 2-bit victim way and its one-hot form to select the way write enables for the fill.

## Interface
- NUM_SETS, 16, number of cache sets; must be a power of two, at least 2
- SET_W, $clog2(NUM_SETS), set index width (derived; do not override)
- clk  in  1  single clock, all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- access_valid  in  1  record a hit/fill this cycle
- access_set  in  SET_W  set of recorded access
- access_way  in  2  way of recorded access
- victim_req_valid  in  1  victim request
- victim_req_ready  out  1  request accepted when valid && ready
- victim_set  in  SET_W  set needing a victim, sampled at accept
- way_valid  in  4  tag-array valid bits of victim_set, sampled at accept
- victim_valid  out  1  victim result available
- victim_ready  in  1  consumer takes result
- victim_way  out  2  selected way
- victim_onehot  out  4  one-hot of victim_way, bit i = way i

## Operation
- PLRU bits per set, b[2:0]:
  - b0: 0 points the victim to ways 0/1, 1 points it to ways 2/3.
  - b1: 0 means way 0, 1 means way 1.
  - b2: 0 means way 2, 1 means way 3.
- Touch(w) makes w the MRU:
  - w=0 gives b0=1, b1=1.
  - w=1 gives b0=1, b1=0.
  - w=2 gives b0=0, b2=1.
  - w=3 gives b0=0, b2=0.
  - The bit not on w's path is unchanged.
- Victim selection, done in LOOKUP:
  - If way_valid_q != 4'hF, the victim is the lowest-index 0 bit.
  - Otherwise it is the PLRU pointed way, using the set's bits at that cycle.
- FSM states:
  - IDLE: victim_req_ready=1. On handshake, latch the set and way_valid and go to LOOKUP.
  - LOOKUP: compute the victim, register it to victim_way, go to RESP.
  - RESP: victim_valid=1 and outputs held stable. On victim_ready, commit Touch(victim_way) to the latched set and go to IDLE.
- Access updates are accepted in every state, with no backpressure. The array update lands at the next edge.
- Access and commit in the same cycle:
  - Same set: the new bits are Touch(Touch(bits, access_way), victim_way), so the victim ends as MRU.
  - Different sets: both updates are applied.
- An access update arriving during RESP does not change the victim already presented.
- Reset, including mid-request:
  - All sets are cleared to b=000, the FSM goes to IDLE, and the latched request is dropped.
  - Reset values: victim_req_ready=1, victim_valid=0, victim_way=2'b00, victim_onehot=4'b0001.

## Timing
- An access at edge N is visible to a LOOKUP at cycle N+1 or later.
- Accept at edge N, LOOKUP in cycle N+1, victim_valid high from cycle N+2.
- Latency from accept to victim_valid is 2 cycles.
- victim_req_ready is low from the cycle after accept until the cycle after the commit edge.
- Minimum request spacing is 3 cycles when victim_ready is held at 1.
- victim_valid stays high with stable outputs until victim_ready is sampled high; there is no timeout.
- victim_onehot is combinational from the registered victim_way; there are no other combinational input-to-output paths.

## Structure
- Shared cache package holds:
  - way index width (2) and WAYS=4
  - the PLRU bit-position constants
  - a touch function and a plru_victim function, reused by the cache top and the scoreboard model
- The PLRU array is flip-flop based: NUM_SETS x 3 bits, written through one merged update port.
- Sub-module: instantiate the team's existing 2-to-4 way `decoder` for victim_onehot.

## Test plan
- After reset, request set 0 with way_valid=4'hF and victim_ready=1 → victim_way=0 and victim_onehot=0001 at cycle 2 after accept; set 0 bits then read 011.
- way_valid=4'b1011 → victim_way=2, regardless of PLRU state.
- Set 5: touch ways 0, 2, 1, 3 in order, then request with all ways valid → victim_way=0. After commit, the next request gives victim_way=2.
- Hold victim_ready=0 for 10 cycles while touching set 5 way 0 → victim_way stays stable. On release, the same-cycle access (way 1) plus commit on set 5 gives bits Touch(Touch(b,1),victim).
- Assert rst in RESP → victim_valid=0 and victim_req_ready=1 immediately; the next request on any set returns way 0.
- Back-to-back requests with victim_ready=1 → accepts exactly 3 cycles apart; random access/request mix checked against the package reference model.
